// File: rtl/atm_keypad_if.sv
// Keypad-to-core bundle for the ATM keypad encoder: scanner keystrokes in,
// request words with a valid/ready handshake plus exit/error pulses out.
interface atm_keypad_if #(
    parameter int ACC_W = 12,
    parameter int AMT_W = 11
);
    logic             key_valid;
    logic [3:0]       key_code;
    logic             req_ready;
    logic             req_valid;
    logic [ACC_W-1:0] acc_number;
    logic [3:0]       pin;
    logic [2:0]       menu_option;
    logic [AMT_W-1:0] amount;
    logic [ACC_W-1:0] dest_acc;
    logic             exit;
    logic             entry_error;

    // master: scanner + ATM core side; slave: the encoder itself
    modport master (
        output key_valid, key_code, req_ready,
        input  req_valid, acc_number, pin, menu_option, amount, dest_acc,
               exit, entry_error
    );

    modport slave (
        input  key_valid, key_code, req_ready,
        output req_valid, acc_number, pin, menu_option, amount, dest_acc,
               exit, entry_error
    );
endinterface

// File: rtl/atm_keypad_encoder.sv
// Decimal keystroke accumulator feeding the ATM core: builds account, PIN,
// option, amount and destination words and presents them on a handshake.
module atm_keypad_encoder #(
    parameter int ACC_W   = 12,
    parameter int AMT_W   = 11,
    parameter int MAX_DIG = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    atm_keypad_if.slave  bus
);
    localparam logic [2:0] S_ACC   = 3'd0;
    localparam logic [2:0] S_PIN   = 3'd1;
    localparam logic [2:0] S_LOGIN = 3'd2;
    localparam logic [2:0] S_OPT   = 3'd3;
    localparam logic [2:0] S_AMT   = 3'd4;
    localparam logic [2:0] S_DEST  = 3'd5;
    localparam logic [2:0] S_ISSUE = 3'd6;

    localparam logic [19:0] ACC_MAX = 20'((1 << ACC_W) - 1);
    localparam logic [19:0] AMT_MAX = 20'((1 << AMT_W) - 1);
    localparam logic [19:0] PIN_MAX = 20'd15;
    localparam logic [19:0] OPT_MAX = 20'd9;

    logic [2:0]       state_reg, state_next;
    logic [15:0]      acc_reg, acc_next;
    logic [3:0]       cnt_reg, cnt_next;
    logic             rv_reg, rv_next;
    logic [ACC_W-1:0] accnum_reg, accnum_next;
    logic [3:0]       pin_reg, pin_next;
    logic [2:0]       opt_reg, opt_next;
    logic [AMT_W-1:0] amt_reg, amt_next;
    logic [ACC_W-1:0] dest_reg, dest_next;
    logic             exit_reg, exit_next;
    logic             err_reg, err_next;

    logic        is_digit, is_enter, is_clear, is_cancel, is_illegal, in_entry;
    logic [3:0]  limit;
    logic [19:0] field_max;
    logic [19:0] cand;

    assign is_digit   = (bus.key_code <= 4'd9);
    assign is_enter   = (bus.key_code == 4'hA);
    assign is_clear   = (bus.key_code == 4'hB);
    assign is_cancel  = (bus.key_code == 4'hC);
    assign is_illegal = (bus.key_code >= 4'hD);
    assign in_entry   = (state_reg == S_ACC) || (state_reg == S_PIN) || (state_reg == S_OPT) ||
                        (state_reg == S_AMT) || (state_reg == S_DEST);
    assign cand       = 20'(acc_reg) * 20'd10 + 20'(bus.key_code);

    always_comb begin
        limit     = 4'(MAX_DIG);
        field_max = ACC_MAX;
        case (state_reg)
            S_PIN:   begin limit = 4'd2; field_max = PIN_MAX; end
            S_OPT:   begin limit = 4'd1; field_max = OPT_MAX; end
            S_AMT:   field_max = AMT_MAX;
            default: ;
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        acc_next    = acc_reg;
        cnt_next    = cnt_reg;
        rv_next     = rv_reg;
        accnum_next = accnum_reg;
        pin_next    = pin_reg;
        opt_next    = opt_reg;
        amt_next    = amt_reg;
        dest_next   = dest_reg;
        exit_next   = 1'b0;
        err_next    = 1'b0;

        if (rv_reg && bus.req_ready) begin
            rv_next    = 1'b0;
            state_next = S_OPT;
        end

        if (bus.key_valid) begin
            if (is_cancel) begin
                // CANCEL overrides everything, including a completing handshake
                exit_next   = 1'b1;
                rv_next     = 1'b0;
                state_next  = S_ACC;
                acc_next    = '0;
                cnt_next    = '0;
                accnum_next = '0;
                pin_next    = '0;
                opt_next    = '0;
                amt_next    = '0;
                dest_next   = '0;
            end else if (is_illegal) begin
                err_next = 1'b1;
            end else if (!rv_reg && in_entry) begin
                if (is_digit) begin
                    if (cnt_reg >= limit || cand > field_max) begin
                        err_next = 1'b1;
                        acc_next = '0;
                        cnt_next = '0;
                    end else begin
                        acc_next = cand[15:0];
                        cnt_next = cnt_reg + 4'd1;
                    end
                end else if (is_enter) begin
                    acc_next = '0;
                    cnt_next = '0;
                    if (cnt_reg == 4'd0) begin
                        err_next = 1'b1;
                    end else begin
                        case (state_reg)
                            S_ACC: begin
                                accnum_next = acc_reg[ACC_W-1:0];
                                state_next  = S_PIN;
                            end
                            S_PIN: begin
                                pin_next   = acc_reg[3:0];
                                opt_next   = 3'd0;
                                state_next = S_LOGIN;
                                rv_next    = 1'b1;
                            end
                            S_OPT: begin
                                if (acc_reg == 16'd3) begin
                                    opt_next   = 3'd3;
                                    state_next = S_ISSUE;
                                    rv_next    = 1'b1;
                                end else if (acc_reg >= 16'd4 && acc_reg <= 16'd6) begin
                                    opt_next   = acc_reg[2:0];
                                    state_next = S_AMT;
                                end else begin
                                    err_next = 1'b1;
                                end
                            end
                            S_AMT: begin
                                amt_next = acc_reg[AMT_W-1:0];
                                if (opt_reg == 3'd6) begin
                                    state_next = S_DEST;
                                end else begin
                                    state_next = S_ISSUE;
                                    rv_next    = 1'b1;
                                end
                            end
                            default: begin
                                dest_next  = acc_reg[ACC_W-1:0];
                                state_next = S_ISSUE;
                                rv_next    = 1'b1;
                            end
                        endcase
                    end
                end else if (is_clear) begin
                    acc_next = '0;
                    cnt_next = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_ACC;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            rv_reg     <= 1'b0;
            accnum_reg <= '0;
            pin_reg    <= '0;
            opt_reg    <= '0;
            amt_reg    <= '0;
            dest_reg   <= '0;
            exit_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            acc_reg    <= acc_next;
            cnt_reg    <= cnt_next;
            rv_reg     <= rv_next;
            accnum_reg <= accnum_next;
            pin_reg    <= pin_next;
            opt_reg    <= opt_next;
            amt_reg    <= amt_next;
            dest_reg   <= dest_next;
            exit_reg   <= exit_next;
            err_reg    <= err_next;
        end
    end

    assign bus.req_valid   = rv_reg;
    assign bus.acc_number  = accnum_reg;
    assign bus.pin         = pin_reg;
    assign bus.menu_option = opt_reg;
    assign bus.amount      = amt_reg;
    assign bus.dest_acc    = dest_reg;
    assign bus.exit        = exit_reg;
    assign bus.entry_error = err_reg;
endmodule
